// File: rtl/board_click_ctrl.sv
// ---------------------------------------------------------------------------
// board_click_ctrl
//
// Owns the ROWS x COLS game board for a minesweeper-style game. Detects rising
// edges on the select/flag buttons, applies them to the cell under the cursor,
// enforces the flag limit, counts revealed safe cells, detects win/loss and,
// after a loss, sweeps the board one cell per cycle to expose mines and mark
// wrong flags.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst            synchronous active-high reset
//   start          new-game request (level)
//   select         reveal button (level, rising edge used)
//   flag           flag button (level, rising edge used)
//   pos_x, pos_y   cursor row / column
//   mine_map       mine layout, bit x*COLS+y, latched on start
//   matrizJuego    board cell codes (registered)
//   game_state     0 IDLE, 1 PLAY (also during sweep), 2 LOST, 3 WON
//   busy           high while the post-loss sweep runs
//   revealed_count safe cells revealed so far
//   flag_count     flags currently placed
// ---------------------------------------------------------------------------
module board_click_ctrl #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int CELL_W    = 4,
    parameter int MAX_FLAGS = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   select,
    input  logic                                   flag,
    input  logic [$clog2(ROWS)-1:0]                pos_x,
    input  logic [$clog2(COLS)-1:0]                pos_y,
    input  logic [ROWS*COLS-1:0]                   mine_map,
    output logic [ROWS-1:0][COLS-1:0][CELL_W-1:0]  matrizJuego,
    output logic [1:0]                             game_state,
    output logic                                   busy,
    output logic [$clog2(ROWS*COLS+1)-1:0]         revealed_count,
    output logic [$clog2(MAX_FLAGS+1)-1:0]         flag_count
);

    localparam int NCELL = ROWS * COLS;
    localparam int IW    = $clog2(NCELL);
    localparam int RCW   = $clog2(NCELL + 1);
    localparam int FCW   = $clog2(MAX_FLAGS + 1);

    localparam logic [CELL_W-1:0] C_HIDDEN = CELL_W'(0);
    localparam logic [CELL_W-1:0] C_SAFE   = CELL_W'(1);
    localparam logic [CELL_W-1:0] C_FLAG   = CELL_W'(2);
    localparam logic [CELL_W-1:0] C_MINE   = CELL_W'(3);
    localparam logic [CELL_W-1:0] C_WRONG  = CELL_W'(4);

    localparam logic [1:0] GS_IDLE = 2'd0;
    localparam logic [1:0] GS_PLAY = 2'd1;
    localparam logic [1:0] GS_LOST = 2'd2;
    localparam logic [1:0] GS_WON  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_SWEEP = 3'd2,
        S_LOST  = 3'd3,
        S_WON   = 3'd4
    } state_t;

    // Number of mines in a layout, used to derive the safe-cell target.
    function automatic logic [RCW-1:0] popcount(input logic [NCELL-1:0] v);
        logic [RCW-1:0] c;
        c = RCW'(0);
        for (int i = 0; i < NCELL; i++) begin
            c = c + RCW'(v[i]);
        end
        return c;
    endfunction

    state_t                       r_state;
    logic [NCELL-1:0][CELL_W-1:0] r_board;      // flat view, index x*COLS+y
    logic [NCELL-1:0]             r_mine_reg;
    logic [RCW-1:0]               r_safe_total;
    logic                         r_sel_q;
    logic                         r_flg_q;
    logic [IW-1:0]                r_sw_idx;
    logic [1:0]                   r_game_state;
    logic                         r_busy;
    logic [RCW-1:0]               r_revealed_count;
    logic [FCW-1:0]               r_flag_count;

    logic                         w_sel_ev;
    logic                         w_flg_ev;
    logic                         w_in_range;
    logic [IW-1:0]                w_idx;
    logic [CELL_W-1:0]            w_cell;
    logic                         w_mine;
    logic [RCW-1:0]               w_rev_next;
    logic [CELL_W-1:0]            w_sw_cell;
    logic                         w_sw_mine;

    assign w_sel_ev   = select & ~r_sel_q;
    assign w_flg_ev   = flag & ~r_flg_q;
    assign w_in_range = (32'(pos_x) < ROWS) && (32'(pos_y) < COLS);
    assign w_idx      = IW'(32'(pos_x) * COLS + 32'(pos_y));
    assign w_cell     = r_board[w_idx];
    assign w_mine     = r_mine_reg[w_idx];
    assign w_rev_next = r_revealed_count + RCW'(1);
    assign w_sw_cell  = r_board[r_sw_idx];
    assign w_sw_mine  = r_mine_reg[r_sw_idx];

    // Expose the flat board as the row/column matrix the renderer reads.
    for (genvar gx = 0; gx < ROWS; gx++) begin : g_row
        for (genvar gy = 0; gy < COLS; gy++) begin : g_col
            assign matrizJuego[gx][gy] = r_board[gx*COLS + gy];
        end
    end

    assign game_state     = r_game_state;
    assign busy           = r_busy;
    assign revealed_count = r_revealed_count;
    assign flag_count     = r_flag_count;

    // Game FSM: button edges, board updates, counters and loss sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_board          <= '0;
            r_mine_reg       <= '0;
            r_safe_total     <= RCW'(0);
            r_sel_q          <= 1'b0;
            r_flg_q          <= 1'b0;
            r_sw_idx         <= IW'(0);
            r_game_state     <= GS_IDLE;
            r_busy           <= 1'b0;
            r_revealed_count <= RCW'(0);
            r_flag_count     <= FCW'(0);
        end else begin
            // Sampled every cycle so a held button never retriggers later.
            r_sel_q <= select;
            r_flg_q <= flag;
            case (r_state)
                S_SWEEP: begin
                    if (w_sw_mine && (w_sw_cell == C_HIDDEN)) begin
                        r_board[r_sw_idx] <= C_MINE;
                    end else if (!w_sw_mine && (w_sw_cell == C_FLAG)) begin
                        r_board[r_sw_idx] <= C_WRONG;
                    end else begin
                        r_board[r_sw_idx] <= w_sw_cell;
                    end
                    if (r_sw_idx == IW'(NCELL - 1)) begin
                        r_state      <= S_LOST;
                        r_game_state <= GS_LOST;
                        r_busy       <= 1'b0;
                    end else begin
                        r_sw_idx <= r_sw_idx + IW'(1);
                    end
                end
                S_IDLE, S_PLAY, S_LOST, S_WON: begin
                    if (start) begin
                        // New game outranks any button event this cycle.
                        r_board          <= '0;
                        r_mine_reg       <= mine_map;
                        r_safe_total     <= RCW'(NCELL) - popcount(mine_map);
                        r_revealed_count <= RCW'(0);
                        r_flag_count     <= FCW'(0);
                        r_state          <= S_PLAY;
                        r_game_state     <= GS_PLAY;
                        r_busy           <= 1'b0;
                    end else if ((r_state == S_PLAY) && w_in_range) begin
                        if (w_flg_ev) begin
                            // Flag beats a simultaneous select.
                            if ((w_cell == C_HIDDEN) && (r_flag_count < FCW'(MAX_FLAGS))) begin
                                r_board[w_idx] <= C_FLAG;
                                r_flag_count   <= r_flag_count + FCW'(1);
                            end else if (w_cell == C_FLAG) begin
                                r_board[w_idx] <= C_HIDDEN;
                                r_flag_count   <= r_flag_count - FCW'(1);
                            end else begin
                                r_board[w_idx] <= w_cell;
                            end
                        end else if (w_sel_ev && (w_cell == C_HIDDEN)) begin
                            if (w_mine) begin
                                r_board[w_idx] <= C_MINE;
                                r_sw_idx       <= IW'(0);
                                r_state        <= S_SWEEP;
                                r_busy         <= 1'b1;
                            end else begin
                                r_board[w_idx]   <= C_SAFE;
                                r_revealed_count <= w_rev_next;
                                // With zero safe cells this never matches.
                                if (w_rev_next == r_safe_total) begin
                                    r_state      <= S_WON;
                                    r_game_state <= GS_WON;
                                end else begin
                                    r_state <= S_PLAY;
                                end
                            end
                        end else begin
                            r_state <= r_state;
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_game_state <= GS_IDLE;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_click_ctrl.sv
// ---------------------------------------------------------------------------
// tb_board_click_ctrl
//
// Directed bench for board_click_ctrl (8x8 board, MAX_FLAGS = 2). Each step
// pushes its expected outputs onto a scoreboard queue before the clock edge;
// after the edge the queue is drained and every entry compared with the DUT.
// ---------------------------------------------------------------------------
module tb_board_click_ctrl;

    localparam int ROWS      = 8;
    localparam int COLS      = 8;
    localparam int CELL_W    = 4;
    localparam int MAX_FLAGS = 2;

    localparam int K_CELL  = 0;
    localparam int K_STATE = 1;
    localparam int K_BUSY  = 2;
    localparam int K_RCNT  = 3;
    localparam int K_FCNT  = 4;
    localparam int K_ZERO  = 5;
    localparam int K_BLEN  = 6;

    typedef struct {
        int          kind;
        int          x;
        int          y;
        logic [31:0] exp;
    } exp_t;

    logic                                  clk;
    logic                                  rst;
    logic                                  start;
    logic                                  select;
    logic                                  flag;
    logic [2:0]                            pos_x;
    logic [2:0]                            pos_y;
    logic [ROWS*COLS-1:0]                  mine_map;
    logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] matrizJuego;
    logic [1:0]                            game_state;
    logic                                  busy;
    logic [6:0]                            revealed_count;
    logic [1:0]                            flag_count;

    exp_t sbq[$];
    int   n_checks;
    int   n_pass;
    int   n_fail;
    int   busy_cnt;

    board_click_ctrl #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .CELL_W    (CELL_W),
        .MAX_FLAGS (MAX_FLAGS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .select         (select),
        .flag           (flag),
        .pos_x          (pos_x),
        .pos_y          (pos_y),
        .mine_map       (mine_map),
        .matrizJuego    (matrizJuego),
        .game_state     (game_state),
        .busy           (busy),
        .revealed_count (revealed_count),
        .flag_count     (flag_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            K_CELL:  return "cell";
            K_STATE: return "game_state";
            K_BUSY:  return "busy";
            K_RCNT:  return "revealed_count";
            K_FCNT:  return "flag_count";
            K_ZERO:  return "board_all_zero";
            K_BLEN:  return "busy_length";
            default: return "unknown";
        endcase
    endfunction

    task automatic expect_v(input int kind, input int x, input int y, input int val);
        exp_t e;
        e.kind = kind;
        e.x    = x;
        e.y    = y;
        e.exp  = 32'(val);
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.kind)
                K_CELL:  obs = 32'(matrizJuego[e.x][e.y]);
                K_STATE: obs = 32'(game_state);
                K_BUSY:  obs = 32'(busy);
                K_RCNT:  obs = 32'(revealed_count);
                K_FCNT:  obs = 32'(flag_count);
                K_ZERO:  obs = (matrizJuego === '0) ? 32'd1 : 32'd0;
                K_BLEN:  obs = 32'(busy_cnt);
                default: obs = 32'hDEAD_BEEF;
            endcase
            n_checks++;
            assert (obs === e.exp) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s(%0d,%0d) observed=%0d expected=%0d",
                       kname(e.kind), e.x, e.y, obs, e.exp);
            end
        end
    endtask

    // One clock edge, then compare everything queued for it.
    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic pulse_flag(input int x, input int y);
        pos_x = 3'(x);
        pos_y = 3'(y);
        flag  = 1'b1;
        tick();
        flag  = 1'b0;
        tick();
    endtask

    task automatic pulse_sel(input int x, input int y);
        pos_x  = 3'(x);
        pos_y  = 3'(y);
        select = 1'b1;
        tick();
        select = 1'b0;
        tick();
    endtask

    task automatic new_game(input logic [ROWS*COLS-1:0] map);
        mine_map = map;
        start    = 1'b1;
        expect_v(K_STATE, 0, 0, 1);
        expect_v(K_ZERO,  0, 0, 1);
        expect_v(K_RCNT,  0, 0, 0);
        expect_v(K_FCNT,  0, 0, 0);
        expect_v(K_BUSY,  0, 0, 0);
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ROWS*COLS-1:0] map;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        busy_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        select   = 1'b0;
        flag     = 1'b0;
        pos_x    = 3'd0;
        pos_y    = 3'd0;
        mine_map = '0;

        // Reset values
        expect_v(K_STATE, 0, 0, 0);
        expect_v(K_BUSY,  0, 0, 0);
        expect_v(K_RCNT,  0, 0, 0);
        expect_v(K_FCNT,  0, 0, 0);
        expect_v(K_ZERO,  0, 0, 1);
        tick();
        rst = 1'b0;

        // Start with a single mine at (0,0)
        map = '0;
        map[0] = 1'b1;
        new_game(map);

        // Flag placement and the limit of two
        expect_v(K_CELL, 1, 1, 2); expect_v(K_FCNT, 0, 0, 1);
        pulse_flag(1, 1);
        expect_v(K_CELL, 1, 2, 2); expect_v(K_FCNT, 0, 0, 2);
        pulse_flag(1, 2);
        expect_v(K_CELL, 1, 3, 0); expect_v(K_FCNT, 0, 0, 2);
        pulse_flag(1, 3);
        expect_v(K_CELL, 1, 1, 0); expect_v(K_FCNT, 0, 0, 1);
        pulse_flag(1, 1);

        // Select held for five cycles counts once
        pos_x  = 3'd2;
        pos_y  = 3'd2;
        select = 1'b1;
        expect_v(K_CELL, 2, 2, 1); expect_v(K_RCNT, 0, 0, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            expect_v(K_RCNT, 0, 0, 1);
            tick();
        end
        select = 1'b0;
        tick();

        // Flag on a revealed cell does nothing
        expect_v(K_CELL, 2, 2, 1); expect_v(K_FCNT, 0, 0, 1);
        pulse_flag(2, 2);

        // Select and flag rising together: flag wins
        pos_x  = 3'd3;
        pos_y  = 3'd3;
        select = 1'b1;
        flag   = 1'b1;
        expect_v(K_CELL, 3, 3, 2); expect_v(K_FCNT, 0, 0, 2); expect_v(K_RCNT, 0, 0, 1);
        tick();
        select = 1'b0;
        flag   = 1'b0;
        tick();

        // Select on a flagged cell leaves it flagged
        expect_v(K_CELL, 3, 3, 2); expect_v(K_RCNT, 0, 0, 1); expect_v(K_STATE, 0, 0, 1);
        pulse_sel(3, 3);

        // Win: 63 mines, only (7,7) safe
        map = '1;
        map[63] = 1'b0;
        new_game(map);
        expect_v(K_CELL, 7, 7, 1); expect_v(K_RCNT, 0, 0, 1); expect_v(K_STATE, 0, 0, 3);
        pulse_sel(7, 7);
        expect_v(K_CELL, 0, 0, 0); expect_v(K_FCNT, 0, 0, 0); expect_v(K_STATE, 0, 0, 3);
        pulse_flag(0, 0);

        // Loss with sweep: mines at (0,0) and (5,5), flag on safe (4,4)
        map = '0;
        map[0]  = 1'b1;
        map[45] = 1'b1;
        new_game(map);
        expect_v(K_CELL, 4, 4, 2); expect_v(K_FCNT, 0, 0, 1);
        pulse_flag(4, 4);
        pos_x  = 3'd5;
        pos_y  = 3'd5;
        select = 1'b1;
        expect_v(K_CELL, 5, 5, 3); expect_v(K_BUSY, 0, 0, 1); expect_v(K_STATE, 0, 0, 1);
        tick();
        select   = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            if (busy !== 1'b1) break;
            busy_cnt++;
            if (k == 3) begin
                pos_x  = 3'd6;
                pos_y  = 3'd6;
                select = 1'b1;
                flag   = 1'b1;
            end else begin
                select = 1'b0;
                flag   = 1'b0;
            end
            tick();
        end
        select = 1'b0;
        flag   = 1'b0;
        expect_v(K_BLEN,  0, 0, 64);
        expect_v(K_CELL,  0, 0, 3);
        expect_v(K_CELL,  4, 4, 4);
        expect_v(K_CELL,  5, 5, 3);
        expect_v(K_CELL,  6, 6, 0);
        expect_v(K_STATE, 0, 0, 2);
        expect_v(K_BUSY,  0, 0, 0);
        expect_v(K_FCNT,  0, 0, 1);
        expect_v(K_RCNT,  0, 0, 0);
        drain();

        // Board frozen after a loss
        expect_v(K_CELL, 1, 1, 0); expect_v(K_STATE, 0, 0, 2);
        pulse_sel(1, 1);

        // Reset ten cycles into a sweep
        new_game(map);
        pos_x  = 3'd0;
        pos_y  = 3'd0;
        select = 1'b1;
        expect_v(K_BUSY, 0, 0, 1); expect_v(K_CELL, 0, 0, 3);
        tick();
        select = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        rst = 1'b1;
        expect_v(K_BUSY,  0, 0, 0);
        expect_v(K_STATE, 0, 0, 0);
        expect_v(K_ZERO,  0, 0, 1);
        expect_v(K_RCNT,  0, 0, 0);
        expect_v(K_FCNT,  0, 0, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
